vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 130 +++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, registered syncs, display-enable and frame pulses.
// Optional clock-per-pixel divider enabled by defining VGA_TIMING_PIXDIV_EN.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CW       = 10,
    parameter int PIX_DIV  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic          vga_h_sync,
    output logic          vga_v_sync,
    output logic          inDisplayArea,
    output logic [CW-1:0] CounterX,
    output logic [CW-1:0] CounterY,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_count
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = V_ACTIVE + V_FP + V_SYNC;
    localparam logic [CW-1:0] X_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(V_TOTAL - 1);

    generate
        if (H_TOTAL >= (1 << CW) || V_TOTAL >= (1 << CW)) begin : g_bad_cw
            $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
        end
        if (PIX_DIV < 1) begin : g_bad_div
            $error("vga_timing_gen: PIX_DIV must be >= 1");
        end
    endgenerate

    logic tick;

`ifdef VGA_TIMING_PIXDIV_EN
    localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    logic [DW-1:0] div_q, div_d;

    // Divider restarts whenever en drops so a resumed line keeps full pixel widths.
    always_comb begin
        tick  = en && (div_q == DW'(PIX_DIV - 1));
        div_d = '0;
        if (en && !tick) div_d = div_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_q <= '0;
        else        div_q <= div_d;
    end
`else
    assign tick = en;
`endif

    logic [CW-1:0] cx_q, cx_d, cy_q, cy_d;
    logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic          ls_q, ls_d, fs_q, fs_d;
    logic [7:0]    fc_q, fc_d;

    // Decode from the next counter values so every registered output matches the counters it rides with.
    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        hs_d = hs_q;
        vs_d = vs_q;
        de_d = de_q;
        fc_d = fc_q;
        ls_d = 1'b0;
        fs_d = 1'b0;
        if (tick) begin
            if (cx_q == X_LAST) begin
                cx_d = '0;
                cy_d = (cy_q == Y_LAST) ? '0 : cy_q + 1'b1;
            end else begin
                cx_d = cx_q + 1'b1;
            end
            ls_d = (cx_d == '0);
            fs_d = ls_d && (cy_d == '0);
            if (fs_d) fc_d = fc_q + 8'd1;
            hs_d = (int'(cx_d) >= HS_BEG && int'(cx_d) < HS_END) ? H_POL : ~H_POL;
            vs_d = (int'(cy_d) >= VS_BEG && int'(cy_d) < VS_END) ? V_POL : ~V_POL;
            de_d = (int'(cx_d) < H_ACTIVE) && (int'(cy_d) < V_ACTIVE);
        end
    end

    // Reset parks at the last pixel of the frame so the first tick lands on (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cx_q <= X_LAST;
            cy_q <= Y_LAST;
            hs_q <= ~H_POL;
            vs_q <= ~V_POL;
            de_q <= 1'b0;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
            fc_q <= 8'd0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            de_q <= de_d;
            ls_q <= ls_d;
            fs_q <= fs_d;
            fc_q <= fc_d;
        end
    end

    assign CounterX      = cx_q;
    assign CounterY      = cy_q;
    assign vga_h_sync    = hs_q;
    assign vga_v_sync    = vs_q;
    assign inDisplayArea = de_q;
    assign line_start    = ls_q;
    assign frame_start   = fs_q;
    assign frame_count   = fc_q;
endmodule
